// File: rtl/load_queue.sv
// In-order DEPTH-entry load queue for the OTTER out-of-order backend.
// Pending operands wake up by snooping the CDB; the head issues one memory read at a time.
module load_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [XLEN-1:0]        alloc_V1,
  input  logic [XLEN-1:0]        alloc_V2,
  input  logic                   alloc_V1_valid,
  input  logic                   alloc_V2_valid,
  input  logic [TAG_W-1:0]       alloc_Q1,
  input  logic [TAG_W-1:0]       alloc_Q2,
  input  logic [TAG_W-1:0]       alloc_rd_tag,
  input  logic [2:0]             alloc_mem_type,
  input  logic                   cdb_in_valid,
  input  logic [TAG_W-1:0]       cdb_in_tag,
  input  logic [XLEN-1:0]        cdb_in_val,
  output logic                   MEM_READ,
  output logic [XLEN-1:0]        MEM_ADDR2,
  output logic [1:0]             MEM_SIZE,
  output logic                   MEM_SIGN,
  input  logic                   mem_gnt,
  input  logic                   mem_resp_valid,
  input  logic [XLEN-1:0]        mem_data_in,
  output logic                   CDB_req,
  input  logic                   CDB_gnt,
  output logic [XLEN-1:0]        CDB_val,
  output logic [TAG_W-1:0]       CDB_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_BCAST = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [XLEN-1:0]  v1       [DEPTH];
  logic [XLEN-1:0]  v2       [DEPTH];
  logic [TAG_W-1:0] q1       [DEPTH];
  logic [TAG_W-1:0] q2       [DEPTH];
  logic [TAG_W-1:0] rd_tag   [DEPTH];
  logic [2:0]       mem_type [DEPTH];
  logic [DEPTH-1:0] v1_valid;
  logic [DEPTH-1:0] v2_valid;
  logic [DEPTH-1:0] occupied;

  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W:0]   cand_ptr;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W-1:0] cand_idx;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       pop;
  logic       full;
  logic       alloc_fire;
  logic       alloc_v1_hit;
  logic       alloc_v2_hit;
  logic       cand_ready;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] mt, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (mt[1:0])
      2'd0:    r = mt[2] ? {{(XLEN-8){1'b0}}, d[7:0]}   : {{(XLEN-8){d[7]}}, d[7:0]};
      2'd1:    r = mt[2] ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign count    = tail - head;
  assign full     = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);

  assign alloc_ready  = !RST && !full && (state != ST_DRAIN);
  assign alloc_fire   = alloc_valid && alloc_ready && !flush;
  assign alloc_v1_hit = cdb_in_valid && !alloc_V1_valid && (alloc_Q1 == cdb_in_tag);
  assign alloc_v2_hit = cdb_in_valid && !alloc_V2_valid && (alloc_Q2 == cdb_in_tag);

  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PTR_W'(i) - head_idx} < count);
    end
  end

  // Readiness of the entry that will sit at the head next cycle, including this
  // cycle's CDB broadcast and a same-cycle allocation into an otherwise empty queue.
  assign cand_ptr = (state == ST_BCAST) ? head + PTR_ONE : head;
  assign cand_idx = cand_ptr[PTR_W-1:0];

  always_comb begin
    cand_ready = 1'b0;
    if (cand_ptr != tail) begin
      cand_ready = (v1_valid[cand_idx] || (cdb_in_valid && q1[cand_idx] == cdb_in_tag)) &&
                   (v2_valid[cand_idx] || (cdb_in_valid && q2[cand_idx] == cdb_in_tag));
    end else if (alloc_fire) begin
      cand_ready = (alloc_V1_valid || alloc_v1_hit) && (alloc_V2_valid || alloc_v2_hit);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE:  if (cand_ready) state_next = ST_REQ;
      ST_REQ:   if (mem_gnt) state_next = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_next = ST_BCAST;
      ST_BCAST: begin
        if (CDB_gnt) begin
          pop        = 1'b1;
          state_next = cand_ready ? ST_REQ : ST_IDLE;
        end
      end
      ST_DRAIN: if (mem_resp_valid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // A read still owed by memory must be absorbed in DRAIN; one arriving now is simply dropped.
    if (flush) begin
      pop = 1'b0;
      if ((state == ST_REQ && mem_gnt) ||
          ((state == ST_WAIT || state == ST_DRAIN) && !mem_resp_valid)) begin
        state_next = ST_DRAIN;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      head     <= '0;
      tail     <= '0;
      v1_valid <= '0;
      v2_valid <= '0;
      CDB_val  <= '0;
      CDB_tag  <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        head     <= '0;
        tail     <= '0;
        v1_valid <= '0;
        v2_valid <= '0;
      end else begin
        if (pop) head <= head + PTR_ONE;
        for (int i = 0; i < DEPTH; i++) begin
          if (occupied[i] && cdb_in_valid && !v1_valid[i] && q1[i] == cdb_in_tag) v1_valid[i] <= 1'b1;
          if (occupied[i] && cdb_in_valid && !v2_valid[i] && q2[i] == cdb_in_tag) v2_valid[i] <= 1'b1;
        end
        if (alloc_fire) begin
          tail               <= tail + PTR_ONE;
          v1_valid[tail_idx] <= alloc_V1_valid || alloc_v1_hit;
          v2_valid[tail_idx] <= alloc_V2_valid || alloc_v2_hit;
        end
      end
      if (state == ST_WAIT && mem_resp_valid && !flush) begin
        CDB_val <= extend(mem_type[head_idx], mem_data_in);
        CDB_tag <= rd_tag[head_idx];
      end
    end
  end

  // Payload needs no reset: nothing reads it unless the matching valid bit or pointer says so.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && cdb_in_valid && !v1_valid[i] && q1[i] == cdb_in_tag) v1[i] <= cdb_in_val;
      if (occupied[i] && cdb_in_valid && !v2_valid[i] && q2[i] == cdb_in_tag) v2[i] <= cdb_in_val;
    end
    if (alloc_fire) begin
      v1[tail_idx]       <= alloc_v1_hit ? cdb_in_val : alloc_V1;
      v2[tail_idx]       <= alloc_v2_hit ? cdb_in_val : alloc_V2;
      q1[tail_idx]       <= alloc_Q1;
      q2[tail_idx]       <= alloc_Q2;
      rd_tag[tail_idx]   <= alloc_rd_tag;
      mem_type[tail_idx] <= alloc_mem_type;
    end
  end

  assign MEM_READ  = (state == ST_REQ);
  assign MEM_ADDR2 = MEM_READ ? v1[head_idx] + v2[head_idx] : '0;
  assign MEM_SIZE  = MEM_READ ? mem_type[head_idx][1:0] : 2'b00;
  assign MEM_SIGN  = MEM_READ && mem_type[head_idx][2];
  assign CDB_req   = (state == ST_BCAST);

endmodule
